// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types and constants for the MEM-stage stall controller.
package mem_stall_ctrl_pkg;

    // Controller states (2-bit encoding kept from the original header).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Stall vector bit positions, one per pipeline register.
    localparam int unsigned STALL_PC     = 0;
    localparam int unsigned STALL_IF_ID  = 1;
    localparam int unsigned STALL_ID_EX  = 2;
    localparam int unsigned STALL_EX_MEM = 3;
    localparam int unsigned STALL_MEM_WB = 4;
    localparam int unsigned STALL_RSVD   = 5;

    // Canonical stall patterns: holding stage i while releasing i+1 bubbles i+1.
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_LOADUSE = 6'b000111; // hold pc..id_ex, bubble into EX
    localparam logic [5:0] STALL_MEM     = 6'b001111; // hold pc..ex_mem, bubble into WB

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Request/stall bundle between the pipeline, data memory and the stall controller.
interface mem_stall_ctrl_if #(
    parameter int unsigned STALL_W = 6
);
    logic               stallreq_id;
    logic               mem_req;
    logic               flush_req;
    logic               dmem_ack;
    logic               dmem_req;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               mem_timeout;

    // Pipeline/memory side: raises requests, observes stall and flush.
    modport master (
        output stallreq_id, mem_req, flush_req, dmem_ack,
        input  dmem_req, stall, flush, mem_timeout
    );

    // Controller side.
    modport slave (
        input  stallreq_id, mem_req, flush_req, dmem_ack,
        output dmem_req, stall, flush, mem_timeout
    );
endinterface

// File: rtl/mem_stall_ctrl_wait_timer.sv
// Saturating wait counter for a pending memory access, with an expire flag
// raised in the last permitted cycle (count == TIMEOUT-1).
module wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles; clear wins over enable and the count never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expire flag decoded straight from the count.
    always_comb begin
        expired = (cnt == CNT_LAST);
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage pipeline sequencer: data memory req/ack handshake, per-stage stall
// vector and flush strobe, arbitrating flush > memory wait > load-use interlock.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned STALL_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stall_ctrl_if.slave      bus
);
    state_t     state;
    logic       dmem_req_q;
    logic       mem_timeout_q;
    logic       expired;
    logic       go_busy;
    logic       go_drain;
    logic       timer_clr;
    logic       timer_en;
    logic [5:0] stall_d;

    // Transition strobes shared by the FSM, the timer and the stall decode.
    always_comb begin
        go_busy   = (state == ST_IDLE) && bus.mem_req && !bus.flush_req;
        go_drain  = (state == ST_BUSY) && bus.flush_req && !bus.dmem_ack;
        timer_clr = go_busy || go_drain;
        timer_en  = (state == ST_BUSY) || (state == ST_DRAIN);
    end

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(expired)
    );

    // Access FSM with registered dmem_req and timeout pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            dmem_req_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            mem_timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_busy) begin
                        state      <= ST_BUSY;
                        dmem_req_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (bus.dmem_ack) begin
                        // A flush that coincides with the ack finds the access complete.
                        state      <= bus.flush_req ? ST_IDLE : ST_DONE;
                        dmem_req_q <= 1'b0;
                    end else if (bus.flush_req) begin
                        // Request stays up until the memory acknowledges.
                        state <= ST_DRAIN;
                    end else if (expired) begin
                        state         <= ST_DONE;
                        dmem_req_q    <= 1'b0;
                        mem_timeout_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (bus.dmem_ack) begin
                        state      <= ST_IDLE;
                        dmem_req_q <= 1'b0;
                    end else if (expired) begin
                        state         <= ST_IDLE;
                        dmem_req_q    <= 1'b0;
                        mem_timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dmem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall decode by priority; reset forces the pipeline controls quiet.
    always_comb begin
        stall_d = STALL_NONE;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (bus.flush_req) begin
                        stall_d = STALL_NONE;
                    end else if (bus.mem_req) begin
                        stall_d = STALL_MEM;
                    end else if (bus.stallreq_id) begin
                        stall_d = STALL_LOADUSE;
                    end
                end
                ST_BUSY: begin
                    if (go_drain || !bus.flush_req) begin
                        stall_d = STALL_MEM;
                    end
                end
                ST_DRAIN: begin
                    stall_d = STALL_MEM;
                end
                default: begin
                    stall_d = STALL_NONE;
                end
            endcase
        end
    end

    // Drive the bundle outputs.
    always_comb begin
        bus.stall       = STALL_W'(stall_d);
        bus.flush       = rst && bus.flush_req;
        bus.dmem_req    = dmem_req_q;
        bus.mem_timeout = mem_timeout_q;
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed-vector bench for mem_stall_ctrl (TIMEOUT=16, STALL_W=6).
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mem_stall_ctrl_if #(.STALL_W(6)) bus ();

    mem_stall_ctrl #(
        .TIMEOUT(16),
        .STALL_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the rising edge, check on the falling edge.
    task automatic cyc(input logic mr, input logic fr, input logic ak, input logic sid,
                       input logic [5:0] e_st, input logic e_rq, input logic e_fl,
                       input logic e_to, input string tag);
        @(posedge clk);
        #1;
        bus.mem_req     = mr;
        bus.flush_req   = fr;
        bus.dmem_ack    = ak;
        bus.stallreq_id = sid;
        @(negedge clk);
        check({tag, ".stall"},   32'(bus.stall),       32'(e_st));
        check({tag, ".req"},     32'(bus.dmem_req),    32'(e_rq));
        check({tag, ".flush"},   32'(bus.flush),       32'(e_fl));
        check({tag, ".timeout"}, 32'(bus.mem_timeout), 32'(e_to));
    endtask

    initial begin
        // Reset held with active requests: outputs must stay quiet.
        bus.mem_req     = 1'b1;
        bus.flush_req   = 1'b1;
        bus.dmem_ack    = 1'b0;
        bus.stallreq_id = 1'b1;
        #12;
        check("rst.stall",   32'(bus.stall),       32'h0);
        check("rst.req",     32'(bus.dmem_req),    32'h0);
        check("rst.flush",   32'(bus.flush),       32'h0);
        check("rst.timeout", 32'(bus.mem_timeout), 32'h0);
        bus.mem_req     = 1'b0;
        bus.flush_req   = 1'b0;
        bus.stallreq_id = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // 1: single load, ack in cycle 3.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t1.c0");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t1.c1");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t1.c2");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "t1.c3");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t1.done");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t1.idle");

        // Stray ack with no request pending is ignored.
        cyc(0, 0, 1, 0, 6'h00, 0, 0, 0, "ack0.c0");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "ack0.c1");

        // 2: back-to-back loads with mem_req held through DONE.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t2.c0");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "t2.ack1");
        cyc(1, 0, 0, 0, 6'h00, 0, 0, 0, "t2.done1");
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t2.idle");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "t2.ack2");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t2.done2");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t2.end");

        // 3: no ack; 16 BUSY cycles, then timeout pulse in DONE.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t3.c0");
        for (int i = 1; i <= 16; i++) cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t3.busy");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 1, "t3.to");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t3.after");

        // 4: flush in BUSY cycle 2, ack in cycle 5, back to IDLE (not DONE) at 6.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t4.c0");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t4.c1");
        cyc(1, 1, 0, 0, 6'h0F, 1, 1, 0, "t4.flush");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t4.drain3");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t4.drain4");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "t4.ack");
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t4.idle");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "t4.reack");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t4.done");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t4.end");

        // 5: load-use interlock alone, then losing to a memory access.
        cyc(0, 0, 0, 1, 6'h07, 0, 0, 0, "t5.lu");
        cyc(1, 0, 0, 1, 6'h0F, 0, 0, 0, "t5.mem_wins");
        cyc(0, 0, 1, 1, 6'h0F, 1, 0, 0, "t5.ack");
        cyc(0, 0, 0, 1, 6'h00, 0, 0, 0, "t5.done");
        cyc(0, 0, 0, 1, 6'h07, 0, 0, 0, "t5.lu2");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t5.end");

        // Flush in IDLE beats a pending load; nothing is launched.
        cyc(1, 1, 0, 1, 6'h00, 0, 1, 0, "fi.flush");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "fi.after");

        // Flush and ack together in BUSY: straight to IDLE.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "fa.c0");
        cyc(1, 1, 1, 0, 6'h00, 1, 1, 0, "fa.both");
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "fa.idle");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "fa.ack");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "fa.done");

        // Timeout while draining: timer restarts on DRAIN entry, IDLE plus pulse after 16.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "dt.c0");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "dt.c1");
        cyc(1, 1, 0, 0, 6'h0F, 1, 1, 0, "dt.flush");
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "dt.drain");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 1, "dt.to");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "dt.after");

        // 6: asynchronous reset in the middle of BUSY.
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t6.c0");
        cyc(1, 0, 0, 0, 6'h0F, 1, 0, 0, "t6.busy");
        #2;
        rst = 1'b0;
        #1;
        check("t6.async.stall", 32'(bus.stall),    32'h0);
        check("t6.async.req",   32'(bus.dmem_req), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_req = 1'b0;
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t6.rel");
        cyc(1, 0, 0, 0, 6'h0F, 0, 0, 0, "t6.idle");
        cyc(1, 0, 1, 0, 6'h0F, 1, 0, 0, "t6.ack");
        cyc(0, 0, 0, 0, 6'h00, 0, 0, 0, "t6.done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
